ps2_receiver: RTL and testbench
===============================

PS2_RECEIVER -- requirements
Module: ps2_receiver

Interface
REQ-001 Parameter FILTER_LEN, default 4: number of consecutive equal synchronized samples required before ps2_clk changes its filtered level.
REQ-002 Parameter TIMEOUT_COUNT, default 5000: maximum clk cycles allowed between falling edges inside a frame.
REQ-003 Parameter TIMEOUT_WIDTH, default 13: bit width of the timeout counter; it SHALL hold TIMEOUT_COUNT.
REQ-004 clk  input  1  system clock; the block uses one clock.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 ps2_clk  input  1  raw PS/2 clock pin level, asynchronous to clk.
REQ-007 ps2_data  input  1  raw PS/2 data pin level, asynchronous to clk.
REQ-008 inhibit  input  1  high while the host is pulling ps2_clk low (the reset-response pulldown); the receiver ignores the bus.
REQ-009 data  output  8  last received byte; holds its value until the next valid frame.
REQ-010 data_valid  output  1  one-cycle pulse marking a good frame.
REQ-011 bat_done  output  1  one-cycle pulse when a good frame carries 0xAA; drives the downstream reset_required.
REQ-012 parity_err  output  1  one-cycle pulse when a frame fails odd parity.
REQ-013 frame_err  output  1  one-cycle pulse on a bad stop bit or a timeout.

Function
REQ-014 ps2_clk and ps2_data SHALL each pass through a 2-flop synchronizer before any use.
REQ-015 Filtered ps2_clk SHALL change level only after FILTER_LEN consecutive synchronized samples agree; a glitch shorter than this SHALL be ignored.
REQ-016 A falling edge SHALL be detected as a registered 1-to-0 transition of filtered ps2_clk; all bit sampling uses synchronized ps2_data in the same cycle.
REQ-017 FSM states: IDLE, DATA, PARITY, STOP.
REQ-018 IDLE: on a falling edge with data=0 (start bit), go to DATA with the bit index at 0; with data=1, stay in IDLE and flag nothing.
REQ-019 DATA: on each falling edge, shift the bit in LSB-first; after the 8th bit, go to PARITY.
REQ-020 PARITY: on a falling edge, capture the bit and go to STOP.
REQ-021 STOP: on a falling edge, return to IDLE and evaluate the frame.
  - stop=1 and odd parity over 8 data bits plus the parity bit: update data and pulse data_valid.
  - stop=1 and parity bad: pulse parity_err only; data is unchanged.
  - stop=0: pulse frame_err only, whatever the parity.
REQ-022 bat_done SHALL pulse in the same cycle as data_valid when and only when the received byte is 0xAA.
REQ-023 All output pulses SHALL be registered, asserting on the clk cycle after the stop-bit edge is detected; latency from the raw ps2_clk fall to the pulse is at most 2 + FILTER_LEN + 2 clk cycles.
REQ-024 Timeout behaviour:
  - In DATA, PARITY or STOP, the counter increments each cycle and clears on every falling edge.
  - On reaching TIMEOUT_COUNT, the FSM returns to IDLE and frame_err pulses once.
REQ-025 While inhibit=1:
  - The FSM is forced to IDLE, the timeout counter is cleared and a partial frame is discarded without any error pulse.
  - Edges are ignored, and data is unchanged.
REQ-026 After inhibit falls, the next detected falling edge SHALL be treated as a possible start bit.
REQ-027 At most one of data_valid, parity_err and frame_err SHALL be high in any cycle.

Reset
REQ-028 While rst=0, the block SHALL hold these values:
  - FSM in IDLE, bit index 0, shift register 0x00, timeout counter 0.
  - Synchronizers and filter at 1 (idle-high bus).
  - data=0x00, and data_valid, bat_done, parity_err and frame_err all 0.
REQ-029 Reset mid-frame SHALL discard the frame; after release, no output pulses until a complete new frame arrives.

Structure
REQ-030 The shared package ps2_defs SHALL define the state encodings, PS2_BAT_OK=8'hAA, PS2_RESET_CMD=8'hFF, PS2_ACK=8'hFA and the frame length (11).
REQ-031 The timeout SHALL use the codebase counter sub-module (BIT_WIDTH=TIMEOUT_WIDTH, MAX_VALUE=TIMEOUT_COUNT), with its max_val driving the timeout; no other sub-modules.

Verification
REQ-032 Send frame 0x1C with parity=0 and stop=1 at 10 kHz PS/2 clock -> data=0x1C, one data_valid pulse, bat_done=0, no error pulses.
REQ-033 Send frame 0xAA with parity=1 and stop=1 -> data=0xAA, data_valid and bat_done pulse in the same cycle.
REQ-034 Send 0x1C with parity=1 -> a single parity_err pulse, data keeps its previous value; send 0x1C with stop=0 -> a single frame_err pulse.
REQ-035 Stop ps2_clk after 4 data bits for more than TIMEOUT_COUNT cycles -> one frame_err pulse; a following good 0x55 frame -> data=0x55 and data_valid.
REQ-036 Inject a ps2_clk glitch of FILTER_LEN-1 cycles in IDLE -> no state change; raise inhibit mid-frame, then send 0x29 -> no pulses for the aborted frame, then data=0x29 and data_valid.
REQ-037 Assert rst low at bit 5, release it, then send 0xAA -> all outputs 0 during reset, then exactly one data_valid and bat_done pulse.

Source files
------------

// File: rtl/ps2_defs.sv
// Shared PS/2 definitions: receiver state encoding, well-known device bytes
// and the frame length.
package ps2_defs;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_t;

  localparam logic [7:0] PS2_BAT_OK    = 8'hAA;
  localparam logic [7:0] PS2_RESET_CMD = 8'hFF;
  localparam logic [7:0] PS2_ACK       = 8'hFA;
  localparam int         PS2_FRAME_LEN = 11;

  // True when the eight data bits plus the parity bit hold an odd number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] byte_in, input logic par_in);
    return (^{byte_in, par_in}) == 1'b1;
  endfunction

endpackage

// File: rtl/ps2_receiver_counter.sv
// Saturating up-counter with synchronous clear; max_val flags the terminal count.
module ps2_receiver_counter #(
  parameter int BIT_WIDTH = 13,
  parameter int MAX_VALUE = 5000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic en,
  output logic max_val
);

  logic [BIT_WIDTH-1:0] count_r;

  assign max_val = (count_r == BIT_WIDTH'(MAX_VALUE));

  // Count register: clear wins, then count up until the terminal value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= '0;
    end else if (clear) begin
      count_r <= '0;
    end else if (en && !max_val) begin
      count_r <= count_r + BIT_WIDTH'(1);
    end else begin
      count_r <= count_r;
    end
  end

endmodule

// File: rtl/ps2_receiver.sv
// PS/2 device-to-host frame receiver: synchronize, deglitch ps2_clk, shift in
// 11-bit frames on falling edges, and flag good bytes, parity and framing errors.
module ps2_receiver
  import ps2_defs::*;
#(
  parameter int FILTER_LEN    = 4,
  parameter int TIMEOUT_COUNT = 5000,
  parameter int TIMEOUT_WIDTH = 13
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       inhibit,
  output logic [7:0] data,
  output logic       data_valid,
  output logic       bat_done,
  output logic       parity_err,
  output logic       frame_err
);

  localparam int FW = $clog2(FILTER_LEN) + 1;

  logic          clk_meta_r, clk_sync_r, data_meta_r, data_sync_r;
  logic          filt_r, filt_prev_r;
  logic [FW-1:0] filt_cnt_r;
  logic          fall_s, tmo_s, tmo_clear_s;

  ps2_state_t    state_r, state_nxt;
  logic [2:0]    idx_r, idx_nxt;
  logic [7:0]    shift_r, shift_nxt;
  logic          par_r, par_nxt;
  logic [7:0]    data_r, data_nxt;
  logic          dv_r, dv_nxt, bat_r, bat_nxt, perr_r, perr_nxt, ferr_r, ferr_nxt;

  // Two-flop synchronizers for both pins; idle bus is high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_meta_r  <= 1'b1;
      clk_sync_r  <= 1'b1;
      data_meta_r <= 1'b1;
      data_sync_r <= 1'b1;
    end else begin
      clk_meta_r  <= ps2_clk;
      clk_sync_r  <= clk_meta_r;
      data_meta_r <= ps2_data;
      data_sync_r <= data_meta_r;
    end
  end

  // Clock deglitch: the filtered level flips only after FILTER_LEN disagreeing samples in a row.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      filt_r      <= 1'b1;
      filt_prev_r <= 1'b1;
      filt_cnt_r  <= '0;
    end else begin
      filt_prev_r <= filt_r;
      if (clk_sync_r == filt_r) begin
        filt_cnt_r <= '0;
      end else if (filt_cnt_r == FW'(FILTER_LEN - 1)) begin
        filt_r     <= clk_sync_r;
        filt_cnt_r <= '0;
      end else begin
        filt_cnt_r <= filt_cnt_r + FW'(1);
      end
    end
  end

  assign fall_s      = filt_prev_r & ~filt_r;
  assign tmo_clear_s = inhibit | fall_s | (state_r == ST_IDLE);

  ps2_receiver_counter #(
    .BIT_WIDTH (TIMEOUT_WIDTH),
    .MAX_VALUE (TIMEOUT_COUNT)
  ) u_timeout (
    .clk     (clk),
    .rst_n   (rst),
    .clear   (tmo_clear_s),
    .en      (1'b1),
    .max_val (tmo_s)
  );

  // Frame state machine: next state and the pulse values registered below.
  always_comb begin
    state_nxt = state_r;
    idx_nxt   = idx_r;
    shift_nxt = shift_r;
    par_nxt   = par_r;
    data_nxt  = data_r;
    dv_nxt    = 1'b0;
    bat_nxt   = 1'b0;
    perr_nxt  = 1'b0;
    ferr_nxt  = 1'b0;
    if (inhibit) begin
      state_nxt = ST_IDLE;
      idx_nxt   = 3'd0;
    end else if ((state_r != ST_IDLE) && tmo_s && !fall_s) begin
      state_nxt = ST_IDLE;
      idx_nxt   = 3'd0;
      ferr_nxt  = 1'b1;
    end else if (fall_s) begin
      case (state_r)
        ST_IDLE: begin
          if (!data_sync_r) begin
            state_nxt = ST_DATA;
            idx_nxt   = 3'd0;
            shift_nxt = 8'h00;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
        ST_DATA: begin
          shift_nxt = {data_sync_r, shift_r[7:1]};
          if (idx_r == 3'd7) begin
            state_nxt = ST_PARITY;
            idx_nxt   = 3'd0;
          end else begin
            idx_nxt = idx_r + 3'd1;
          end
        end
        ST_PARITY: begin
          par_nxt   = data_sync_r;
          state_nxt = ST_STOP;
        end
        ST_STOP: begin
          state_nxt = ST_IDLE;
          if (!data_sync_r) begin
            ferr_nxt = 1'b1;
          end else if (odd_parity_ok(shift_r, par_r)) begin
            data_nxt = shift_r;
            dv_nxt   = 1'b1;
            bat_nxt  = (shift_r == PS2_BAT_OK);
          end else begin
            perr_nxt = 1'b1;
          end
        end
        default: begin
          state_nxt = ST_IDLE;
          idx_nxt   = 3'd0;
        end
      endcase
    end else begin
      state_nxt = state_r;
    end
  end

  // State, datapath and registered output pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
      idx_r   <= 3'd0;
      shift_r <= 8'h00;
      par_r   <= 1'b0;
      data_r  <= 8'h00;
      dv_r    <= 1'b0;
      bat_r   <= 1'b0;
      perr_r  <= 1'b0;
      ferr_r  <= 1'b0;
    end else begin
      state_r <= state_nxt;
      idx_r   <= idx_nxt;
      shift_r <= shift_nxt;
      par_r   <= par_nxt;
      data_r  <= data_nxt;
      dv_r    <= dv_nxt;
      bat_r   <= bat_nxt;
      perr_r  <= perr_nxt;
      ferr_r  <= ferr_nxt;
    end
  end

  assign data       = data_r;
  assign data_valid = dv_r;
  assign bat_done   = bat_r;
  assign parity_err = perr_r;
  assign frame_err  = ferr_r;

endmodule

// File: tb/tb_ps2_receiver.sv
// Directed bench for ps2_receiver: 10 kHz PS/2 frames on a 1 MHz system clock,
// pulse counters sampled on the falling clk edge.
`timescale 1ns/1ps
module tb_ps2_receiver;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       inhibit = 1'b0;
  logic [7:0] data;
  logic       data_valid, bat_done, parity_err, frame_err;

  int total = 0;
  int bad = 0;
  int dv_cnt = 0, bat_cnt = 0, perr_cnt = 0, ferr_cnt = 0;
  int mutex_cnt = 0, bat_solo_cnt = 0;
  int dv0, bat0, perr0, ferr0;

  always #500 clk = ~clk;

  ps2_receiver dut (
    .clk        (clk),
    .rst        (rst),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .inhibit    (inhibit),
    .data       (data),
    .data_valid (data_valid),
    .bat_done   (bat_done),
    .parity_err (parity_err),
    .frame_err  (frame_err)
  );

  always @(negedge clk) begin
    dv_cnt   <= dv_cnt + int'(data_valid);
    bat_cnt  <= bat_cnt + int'(bat_done);
    perr_cnt <= perr_cnt + int'(parity_err);
    ferr_cnt <= ferr_cnt + int'(frame_err);
    if ((int'(data_valid) + int'(parity_err) + int'(frame_err)) > 1) mutex_cnt <= mutex_cnt + 1;
    if (bat_done && !data_valid) bat_solo_cnt <= bat_solo_cnt + 1;
  end

  task automatic check(input string tag, input int got, input int exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic snap();
    wait_cyc(1);
    dv0 = dv_cnt; bat0 = bat_cnt; perr0 = perr_cnt; ferr0 = ferr_cnt;
  endtask

  // 100 clk cycles per bit: data changes mid-high, clock low for 50 cycles.
  task automatic send_frame(input logic [7:0] b, input logic p, input logic stop, input int nbits);
    logic [10:0] bits;
    bits = {stop, p, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = bits[i];
      wait_cyc(25);
      ps2_clk = 1'b0;
      wait_cyc(50);
      ps2_clk = 1'b1;
      wait_cyc(25);
    end
    ps2_data = 1'b1;
    wait_cyc(20);
  endtask

  task automatic check_deltas(input string tag, input int dv, input int bt, input int pe, input int fe);
    check({tag, ".dv"},   dv_cnt - dv0,   dv);
    check({tag, ".bat"},  bat_cnt - bat0, bt);
    check({tag, ".perr"}, perr_cnt - perr0, pe);
    check({tag, ".ferr"}, ferr_cnt - ferr0, fe);
  endtask

  initial begin
    wait_cyc(5);
    check("rst.data", int'(data), 8'h00);
    check("rst.pulses", int'({data_valid, bat_done, parity_err, frame_err}), 4'h0);
    rst = 1'b1;
    wait_cyc(10);

    snap();
    send_frame(8'h1C, 1'b0, 1'b1, 11);
    check("f1c.data", int'(data), 8'h1C);
    check_deltas("f1c", 1, 0, 0, 0);

    snap();
    send_frame(8'hAA, 1'b1, 1'b1, 11);
    check("faa.data", int'(data), 8'hAA);
    check_deltas("faa", 1, 1, 0, 0);

    snap();
    send_frame(8'h1C, 1'b1, 1'b1, 11);
    check("perr.data", int'(data), 8'hAA);
    check_deltas("perr", 0, 0, 1, 0);

    snap();
    send_frame(8'h1C, 1'b0, 1'b0, 11);
    check("stop0.data", int'(data), 8'hAA);
    check_deltas("stop0", 0, 0, 0, 1);

    snap();
    send_frame(8'h55, 1'b1, 1'b1, 5);
    wait_cyc(5100);
    check_deltas("tmo", 0, 0, 0, 1);
    snap();
    send_frame(8'h55, 1'b1, 1'b1, 11);
    check("f55.data", int'(data), 8'h55);
    check_deltas("f55", 1, 0, 0, 0);

    // A start-bit-like glitch one sample too short must not open a frame.
    snap();
    ps2_data = 1'b0;
    wait_cyc(10);
    ps2_clk = 1'b0;
    wait_cyc(3);
    ps2_clk = 1'b1;
    wait_cyc(10);
    ps2_data = 1'b1;
    wait_cyc(50);
    check_deltas("glitch", 0, 0, 0, 0);
    snap();
    send_frame(8'h33, 1'b1, 1'b1, 11);
    check("f33.data", int'(data), 8'h33);
    check_deltas("f33", 1, 0, 0, 0);

    snap();
    send_frame(8'h29, 1'b0, 1'b1, 5);
    inhibit = 1'b1;
    wait_cyc(5);
    ps2_clk = 1'b0;
    wait_cyc(30);
    ps2_clk = 1'b1;
    wait_cyc(20);
    inhibit = 1'b0;
    wait_cyc(50);
    check("inh.data", int'(data), 8'h33);
    check_deltas("inh", 0, 0, 0, 0);
    snap();
    send_frame(8'h29, 1'b0, 1'b1, 11);
    check("f29.data", int'(data), 8'h29);
    check_deltas("f29", 1, 0, 0, 0);

    send_frame(8'h12, 1'b1, 1'b1, 6);
    rst = 1'b0;
    wait_cyc(3);
    check("midrst.data", int'(data), 8'h00);
    check("midrst.pulses", int'({data_valid, bat_done, parity_err, frame_err}), 4'h0);
    wait_cyc(5);
    rst = 1'b1;
    snap();
    wait_cyc(200);
    check_deltas("postrst", 0, 0, 0, 0);
    snap();
    send_frame(8'hAA, 1'b1, 1'b1, 11);
    check("raa.data", int'(data), 8'hAA);
    check_deltas("raa", 1, 1, 0, 0);

    check("mutex", mutex_cnt, 0);
    check("bat_solo", bat_solo_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
